// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, EX redirect and IF/ID boundary.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    // Memory / EX / decode side
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, in-order imem requests with credit limit,
// {pc, instr} buffer toward decode, redirect flush with in-flight drop.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = PW + 2;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];

    logic [SW-1:0] credit_used;
    logic          req;
    logic          grant;
    logic          empty;
    logic          id_valid;
    logic          pop;
    logic          push;

    // Handshake qualifiers and IF/ID outputs
    always_comb begin
        credit_used = SW'(count_q) + SW'(outst_q);
        req         = !rst && !bus.redirect_valid && (credit_used < SW'(DEPTH));
        grant       = req && bus.imem_gnt;
        empty       = (count_q == '0);
        id_valid    = !empty && !bus.redirect_valid;
        pop         = id_valid && bus.id_ready;
        push        = bus.imem_rvalid && !bus.redirect_valid && (drop_q == '0);

        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_q;
        bus.id_valid  = id_valid;
        bus.id_instr  = empty ? NOP_INSTR : fifo_instr_q[rd_ptr_q];
        bus.id_pc     = empty ? resp_pc_q : fifo_pc_q[rd_ptr_q];
    end

    // Next-state for PCs, counters and buffer pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            outst_d    = outst_q - CW'(bus.imem_rvalid);
            // Pending drops are a subset of outstanding, so every in-flight
            // response not consumed this cycle becomes a drop.
            if (outst_q == '0) begin
                drop_d = '0;
            end else begin
                drop_d = outst_q - CW'(bus.imem_rvalid);
            end
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(grant) - CW'(bus.imem_rvalid);
            if (bus.imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage, written on accepted responses
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (DEPTH=2, RESET_PC=0).
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] d,
                                input logic rd, input logic [31:0] rp, input logic rdy,
                                input logic req, input logic [31:0] a, input logic v,
                                input logic [31:0] i, input logic [31:0] p);
        vec_t t;
        t.gnt = g; t.rv = rv; t.rdata = d; t.redir = rd; t.rpc = rp; t.rdy = rdy;
        t.req = req; t.addr = a; t.vld = v; t.instr = i; t.pc = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] d,
                         input logic rd, input logic [31:0] rp, input logic rdy);
        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = d;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rp;
        bus.id_ready       = rdy;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] a,
                           input logic v, input logic [31:0] i, input logic [31:0] p);
        chk({tag, ".req"},   32'(bus.imem_req), 32'(req));
        chk({tag, ".addr"},  bus.imem_addr,     a);
        chk({tag, ".valid"}, 32'(bus.id_valid), 32'(v));
        chk({tag, ".instr"}, bus.id_instr,      i);
        chk({tag, ".pc"},    bus.id_pc,         p);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        // Streaming with 1-cycle latency, data = address
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h00,0,NOP,32'h00));
        vecs.push_back(mk(1,1'b1,32'h0,   0,32'h0,1, 1,32'h04,0,NOP,32'h00));
        vecs.push_back(mk(1,1'b1,32'h4,   0,32'h0,1, 0,32'h08,1,32'h0,32'h00));
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h08,1,32'h4,32'h04));
        vecs.push_back(mk(1,1'b1,32'h8,   0,32'h0,1, 1,32'h0C,0,NOP,32'h08));
        // Decode stall for 6 cycles: head held, requests stop at the credit limit
        vecs.push_back(mk(1,1'b1,32'hC,   0,32'h0,0, 0,32'h10,1,32'h8,32'h08));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1,1'b0,32'h0,0,32'h0,0, 0,32'h10,1,32'h8,32'h08));
        // Release: 0x8 then 0xC, no loss
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 0,32'h10,1,32'h8,32'h08));
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h10,1,32'hC,32'h0C));
        vecs.push_back(mk(1,1'b1,32'h10,  0,32'h0,1, 1,32'h14,0,NOP,32'h10));
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 0,32'h18,1,32'h10,32'h10));
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h18,0,NOP,32'h14));
        // Redirect to 0x100 with 2 outstanding; both late responses dropped
        vecs.push_back(mk(1,1'b0,32'h0,   1,32'h100,1, 0,32'h1C,0,NOP,32'h14));
        vecs.push_back(mk(1,1'b1,32'hDEAD0014,0,32'h0,1, 0,32'h100,0,NOP,32'h100));
        vecs.push_back(mk(1,1'b1,32'hDEAD0018,0,32'h0,1, 1,32'h100,0,NOP,32'h100));
        vecs.push_back(mk(1,1'b1,32'h100, 0,32'h0,1, 1,32'h104,0,NOP,32'h100));
        vecs.push_back(mk(0,1'b0,32'h0,   0,32'h0,1, 0,32'h108,1,32'h100,32'h100));
        // Redirect coincident with rvalid, unaligned target 0x102
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h108,0,NOP,32'h104));
        vecs.push_back(mk(1,1'b1,32'h104, 1,32'h102,1, 0,32'h10C,0,NOP,32'h104));
        vecs.push_back(mk(0,1'b1,32'hBAD00108,0,32'h0,1, 1,32'h100,0,NOP,32'h100));
        // Grant withheld 4 cycles: address stable, NOP on empty buffer
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1'b0,32'h0,0,32'h0,1, 1,32'h100,0,NOP,32'h100));
        vecs.push_back(mk(1,1'b0,32'h0,   0,32'h0,1, 1,32'h100,0,NOP,32'h100));
        vecs.push_back(mk(0,1'b1,32'h100, 0,32'h0,1, 1,32'h104,0,NOP,32'h100));
        // Redirect while a valid word sits at the head gates id_valid
        vecs.push_back(mk(0,1'b0,32'h0,   0,32'h0,0, 1,32'h104,1,32'h100,32'h100));
        vecs.push_back(mk(0,1'b0,32'h0,   1,32'h200,1, 0,32'h104,0,32'h100,32'h100));
        vecs.push_back(mk(0,1'b0,32'h0,   0,32'h0,1, 1,32'h200,0,NOP,32'h200));

        // Reset state
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].gnt, vecs[n].rv, vecs[n].rdata, vecs[n].redir, vecs[n].rpc, vecs[n].rdy);
            #1;
            chk_out($sformatf("vec%0d", n), vecs[n].req, vecs[n].addr, vecs[n].vld,
                    vecs[n].instr, vecs[n].pc);
        end

        // Async reset with two fetches in flight
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk("ar.addr0", bus.imem_addr, 32'h200);
        @(negedge clk);
        #1;
        chk("ar.addr1", bus.imem_addr, 32'h204);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk("ar.credit", 32'(bus.imem_req), 32'h0);
        #1;
        rst = 1'b1;
        drive(0, 1, 32'hBAD0_0200, 0, 32'h0, 1);
        #1;
        chk_out("ar.during", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk_out("ar.after", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        drive(0, 1, 32'hAAAA_0000, 0, 32'h0, 1);
        #1;
        chk_out("ar.resp", 1'b1, 32'h4, 1'b0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk_out("ar.first", 1'b1, 32'h4, 1'b1, 32'hAAAA_0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
